boarding_controller: RTL and testbench
======================================

# boarding_controller

Sequential successor to the ship-loading stage of the time-machine flow. Counts crew, passengers and cargo as they are boarded or unloaded through a valid/ready handshake, enforces per-channel capacities, and times out if the ship is not ready in time. When loading finishes it emits the 3-bit next-state code consumed by the top-level sequencer: launch (3'b010) or abort (3'b111). Capacities, widths and the timeout are parameters.

## Interface
- W, 4: width of each channel counter.
- CREW_REQ, 4: exact crew count required for launch.
- PAX_MIN, 1: minimum passengers for launch.
- PAX_CAP, 15: passenger capacity, at most 2^W-1.
- CARGO_MIN, 1: minimum cargo units for launch.
- CARGO_CAP, 15: cargo capacity, at most 2^W-1.
- TIMEOUT, 64: cycles allowed in LOADING before abort; must be at least 1.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a loading session; sampled only in IDLE and DONE.
- board_valid  in  1  boarding request present.
- board_kind  in  2  channel: 0 crew, 1 passenger, 2 cargo, 3 illegal.
- board_dir  in  1  1 = board (increment), 0 = unload (decrement).
- board_ready  out  1  request will be accepted this cycle.
- crew_cnt, pax_cnt, cargo_cnt  out  W each  current counts.
- busy  out  1  high in LOADING and CHECK.
- done  out  1  one-cycle pulse on entry to DONE.
- next_state  out  3  result code; valid in DONE.

## Operation
- States: IDLE, LOADING, CHECK, DONE.
- IDLE: counts held at 0; start=1 -> LOADING and timer cleared.
- LOADING: a transfer occurs when board_valid && board_ready. It adds or removes 1 on the selected counter.
- board_ready is high only in LOADING with board_kind != 3. For boarding, the selected count must be below its cap; the crew cap is CREW_REQ. For unloading, the selected count must be nonzero.
- Counters never wrap. A rejected request has no effect and carries no error flag; the requester holds valid or drops it.
- The timer increments every LOADING cycle.
- ok = (crew_cnt == CREW_REQ) && (pax_cnt >= PAX_MIN) && (cargo_cnt >= CARGO_MIN), evaluated on registered counts.
- LOADING -> CHECK when ok is 1, or when the timer reaches TIMEOUT-1.
- CHECK: next_state = 3'b010 if ok, else 3'b111. Then go to DONE. No transfers are accepted in CHECK.
- DONE: counts and next_state are held. start=1 -> LOADING with counts cleared to 0 and the timer cleared.
- Reset in any state -> IDLE, all counts 0, timer 0, busy=0, done=0, next_state=3'b111.

## Timing
- Reset values of all outputs: board_ready=0, counts=0, busy=0, done=0, next_state=3'b111.
- board_ready is combinational from state, counts and board_kind/board_dir. It has no combinational dependency on board_valid.
- A count changes on the edge where the transfer is accepted and is visible the next cycle.
- The transfer that makes ok true is followed by CHECK on the next cycle, then DONE one cycle later. Minimum latency from the last transfer to done is therefore 2 cycles.
- If a transfer and the timeout coincide, the transfer is applied and CHECK evaluates the updated counts.
- If the timeout fires and ok is also true in the same cycle, the result is launch.
- start asserted while busy is ignored.

## Structure
- Package ship_pkg holds:
  - the state enum;
  - the board_kind constants KIND_CREW, KIND_PAX, KIND_CARGO;
  - the next-state codes NS_LAUNCH=3'b010 and NS_ABORT=3'b111, shared with the top-level sequencer.
- Sub-module sat_counter (W, MAX) is instantiated once per channel.
  - Inputs: clk, rst, clr, inc, dec.
  - Outputs: cnt, at_max, at_zero.
  - It saturates at both ends; the parent drives inc/dec only on accepted transfers.
- The FSM, timer and ready logic live in boarding_controller.

## Test plan
- Default parameters: start, then board 4 crew, 1 passenger, 1 cargo on consecutive cycles -> CHECK the cycle after the cargo accept, then done pulse with next_state=3'b010 and counts 4/1/1.
- Board crew a fifth time before the passenger and cargo transfers, with crew_cnt=4 -> board_ready=0 and crew_cnt stays 4. Same check for passengers at 15 (PAX_CAP).
- Unload passenger at pax_cnt=0 -> board_ready=0 and the count stays 0. Board then unload one cargo -> cargo_cnt goes 1 then 0.
- TIMEOUT=8: start, board 2 crew only -> after 8 LOADING cycles next_state=3'b111, done pulses, crew_cnt=2 held in DONE.
- Assert rst mid-LOADING with counts 3/2/1 -> next cycle IDLE, counts 0, next_state=3'b111. Assert start in DONE -> LOADING with counts 0.
- board_kind=3 with valid held for 5 cycles -> board_ready=0 and no count changes. start pulse during LOADING -> ignored.

Source files
------------

// File: rtl/ship_pkg.sv
// Shared types and codes for the ship boarding stage.
package ship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] KIND_CREW    = 2'd0;
    localparam logic [1:0] KIND_PAX     = 2'd1;
    localparam logic [1:0] KIND_CARGO   = 2'd2;
    localparam logic [1:0] KIND_ILLEGAL = 2'd3;

    localparam logic [2:0] NS_LAUNCH = 3'b010;
    localparam logic [2:0] NS_ABORT  = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at 0 and at MAX; synchronous clear.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         at_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt     = cnt_q;
    assign at_max  = (cnt_q == W'(MAX));
    assign at_zero = (cnt_q == '0);

    // Next count: clear wins, then a single-direction step bounded at either end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && !at_zero) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/boarding_controller.sv
// Boarding controller: counts crew/passengers/cargo through a valid/ready
// handshake, enforces capacities, times out, and reports launch or abort.
module boarding_controller
    import ship_pkg::*;
#(
    parameter int W         = 4,
    parameter int CREW_REQ  = 4,
    parameter int PAX_MIN   = 1,
    parameter int PAX_CAP   = 15,
    parameter int CARGO_MIN = 1,
    parameter int CARGO_CAP = 15,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         board_valid,
    input  logic [1:0]   board_kind,
    input  logic         board_dir,
    output logic         board_ready,
    output logic [W-1:0] crew_cnt,
    output logic [W-1:0] pax_cnt,
    output logic [W-1:0] cargo_cnt,
    output logic         busy,
    output logic         done,
    output logic [2:0]   next_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  next_state_q, next_state_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        clr;
    logic        xfer;
    logic        crew_inc, crew_dec, pax_inc, pax_dec, cargo_inc, cargo_dec;
    logic        crew_max, crew_zero, pax_max, pax_zero, cargo_max, cargo_zero;
    logic        sel_max, sel_zero;
    logic [W-1:0] crew_nxt, pax_nxt, cargo_nxt;
    logic        ok, ok_next, timeout;

    sat_counter #(.W(W), .MAX(CREW_REQ)) u_crew (
        .clk(clk), .rst(rst), .clr(clr), .inc(crew_inc), .dec(crew_dec),
        .cnt(crew_cnt), .at_max(crew_max), .at_zero(crew_zero)
    );

    sat_counter #(.W(W), .MAX(PAX_CAP)) u_pax (
        .clk(clk), .rst(rst), .clr(clr), .inc(pax_inc), .dec(pax_dec),
        .cnt(pax_cnt), .at_max(pax_max), .at_zero(pax_zero)
    );

    sat_counter #(.W(W), .MAX(CARGO_CAP)) u_cargo (
        .clk(clk), .rst(rst), .clr(clr), .inc(cargo_inc), .dec(cargo_dec),
        .cnt(cargo_cnt), .at_max(cargo_max), .at_zero(cargo_zero)
    );

    // Ready depends on state, counts, kind and direction only (never on valid).
    always_comb begin
        sel_max  = 1'b1;
        sel_zero = 1'b1;
        case (board_kind)
            KIND_CREW:  begin sel_max = crew_max;  sel_zero = crew_zero;  end
            KIND_PAX:   begin sel_max = pax_max;   sel_zero = pax_zero;   end
            KIND_CARGO: begin sel_max = cargo_max; sel_zero = cargo_zero; end
            default:    begin sel_max = 1'b1;      sel_zero = 1'b1;       end
        endcase
        board_ready = (state_q == ST_LOADING) && (board_kind != KIND_ILLEGAL) &&
                      (board_dir ? !sel_max : !sel_zero);
    end

    // Per-channel step strobes and the counts they will produce.
    always_comb begin
        xfer      = board_valid && board_ready;
        crew_inc  = xfer && (board_kind == KIND_CREW)  &&  board_dir;
        crew_dec  = xfer && (board_kind == KIND_CREW)  && !board_dir;
        pax_inc   = xfer && (board_kind == KIND_PAX)   &&  board_dir;
        pax_dec   = xfer && (board_kind == KIND_PAX)   && !board_dir;
        cargo_inc = xfer && (board_kind == KIND_CARGO) &&  board_dir;
        cargo_dec = xfer && (board_kind == KIND_CARGO) && !board_dir;
        crew_nxt  = crew_cnt  + W'(crew_inc)  - W'(crew_dec);
        pax_nxt   = pax_cnt   + W'(pax_inc)   - W'(pax_dec);
        cargo_nxt = cargo_cnt + W'(cargo_inc) - W'(cargo_dec);
        ok        = (crew_cnt == W'(CREW_REQ)) && (pax_cnt >= W'(PAX_MIN)) &&
                    (cargo_cnt >= W'(CARGO_MIN));
        // Looking at post-transfer counts lets CHECK follow the completing
        // transfer by one cycle; CHECK itself still judges registered counts.
        ok_next   = (crew_nxt == W'(CREW_REQ)) && (pax_nxt >= W'(PAX_MIN)) &&
                    (cargo_nxt >= W'(CARGO_MIN));
        timeout   = (timer_q == TW'(TIMEOUT - 1));
    end

    // FSM next-state, timer and registered output computation.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        next_state_d = next_state_q;
        done_d       = 1'b0;
        clr          = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOADING;
                    timer_d      = '0;
                    clr          = 1'b1;
                    next_state_d = NS_ABORT;
                end
            end
            ST_LOADING: begin
                timer_d = timer_q + TW'(1);
                if (ok_next || timeout) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state_d = ok ? NS_LAUNCH : NS_ABORT;
                done_d       = 1'b1;
                state_d      = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOADING) || (state_d == ST_CHECK);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            next_state_q <= NS_ABORT;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            next_state_q <= next_state_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign next_state = next_state_q;

endmodule

// File: tb/tb_boarding_controller.sv
// Directed bench for boarding_controller: default instance plus a TIMEOUT=8 instance.
module tb_boarding_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst, start, board_valid, board_dir;
    logic [1:0] board_kind;
    logic       board_ready, busy, done;
    logic [3:0] crew_cnt, pax_cnt, cargo_cnt;
    logic [2:0] next_state;

    // TIMEOUT=8 instance
    logic       rst_t, start_t, valid_t, dir_t;
    logic [1:0] kind_t;
    logic       ready_t, busy_t, done_t;
    logic [3:0] crew_t, pax_t, cargo_t;
    logic [2:0] ns_t;

    int checks = 0;
    int errors = 0;

    boarding_controller dut (
        .clk(clk), .rst(rst), .start(start), .board_valid(board_valid),
        .board_kind(board_kind), .board_dir(board_dir), .board_ready(board_ready),
        .crew_cnt(crew_cnt), .pax_cnt(pax_cnt), .cargo_cnt(cargo_cnt),
        .busy(busy), .done(done), .next_state(next_state)
    );

    boarding_controller #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst(rst_t), .start(start_t), .board_valid(valid_t),
        .board_kind(kind_t), .board_dir(dir_t), .board_ready(ready_t),
        .crew_cnt(crew_t), .pax_cnt(pax_t), .cargo_cnt(cargo_t),
        .busy(busy_t), .done(done_t), .next_state(ns_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int c, input int p, input int g);
        check({tag, " crew"},  32'(crew_cnt),  32'(c));
        check({tag, " pax"},   32'(pax_cnt),   32'(p));
        check({tag, " cargo"}, 32'(cargo_cnt), 32'(g));
    endtask

    // Present one request for a single cycle; called and returns at a negedge.
    task automatic req(input logic [1:0] kind, input logic dir, input logic exp_ready, input string tag);
        board_valid = 1'b1;
        board_kind  = kind;
        board_dir   = dir;
        #1;
        check({tag, " ready"}, 32'(board_ready), 32'(exp_ready));
        @(negedge clk);
        board_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; board_valid = 1'b0; board_kind = 2'd0; board_dir = 1'b1;
        rst_t = 1'b1; start_t = 1'b0; valid_t = 1'b0; kind_t = 2'd0; dir_t = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst ready", 32'(board_ready), 0);
        check_counts("rst", 0, 0, 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst ns", 32'(next_state), 32'h7);
        rst = 1'b0;

        // Session 1: 4 crew, 1 pax, 1 cargo -> launch
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s1 busy", 32'(busy), 1);
        for (int unsigned i = 0; i < 4; i++) req(2'd0, 1'b1, 1'b1, "s1 crew");
        check("s1 crew4", 32'(crew_cnt), 4);
        req(2'd0, 1'b1, 1'b0, "s1 crew5");
        check("s1 crew held", 32'(crew_cnt), 4);
        req(2'd1, 1'b1, 1'b1, "s1 pax");
        req(2'd2, 1'b1, 1'b1, "s1 cargo");
        // CHECK cycle
        check("s1 chk busy", 32'(busy), 1);
        check("s1 chk done", 32'(done), 0);
        check_counts("s1 chk", 4, 1, 1);
        board_kind = 2'd1; board_dir = 1'b1; #1;
        check("s1 chk ready", 32'(board_ready), 0);
        @(negedge clk);
        check("s1 done", 32'(done), 1);
        check("s1 ns", 32'(next_state), 32'h2);
        check("s1 done busy", 32'(busy), 0);
        @(negedge clk);
        check("s1 done pulse", 32'(done), 0);
        check("s1 ns held", 32'(next_state), 32'h2);
        check_counts("s1 held", 4, 1, 1);

        // Session 2: restart from DONE clears counts
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_counts("s2 start", 0, 0, 0);
        check("s2 busy", 32'(busy), 1);
        req(2'd1, 1'b0, 1'b0, "s2 pax unload@0");
        check("s2 pax zero", 32'(pax_cnt), 0);
        req(2'd2, 1'b1, 1'b1, "s2 cargo up");
        check("s2 cargo1", 32'(cargo_cnt), 1);
        req(2'd2, 1'b0, 1'b1, "s2 cargo down");
        check("s2 cargo0", 32'(cargo_cnt), 0);
        for (int unsigned i = 0; i < 15; i++) req(2'd1, 1'b1, 1'b1, "s2 pax");
        check("s2 pax15", 32'(pax_cnt), 15);
        req(2'd1, 1'b1, 1'b0, "s2 pax16");
        check("s2 pax held", 32'(pax_cnt), 15);
        for (int unsigned i = 0; i < 13; i++) req(2'd1, 1'b0, 1'b1, "s2 pax dn");
        for (int unsigned i = 0; i < 3; i++) req(2'd0, 1'b1, 1'b1, "s2 crew");
        req(2'd2, 1'b1, 1'b1, "s2 cargo");
        check_counts("s2 321", 3, 2, 1);

        // Illegal kind held valid for 5 cycles
        board_valid = 1'b1; board_kind = 2'd3; board_dir = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            check("s2 illegal ready", 32'(board_ready), 0);
            @(negedge clk);
        end
        board_valid = 1'b0;
        check_counts("s2 illegal", 3, 2, 1);

        // start while LOADING is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_counts("s2 start ign", 3, 2, 1);
        check("s2 start ign busy", 32'(busy), 1);

        // Reset mid-LOADING
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_counts("s2 rst", 0, 0, 0);
        check("s2 rst busy", 32'(busy), 0);
        check("s2 rst ns", 32'(next_state), 32'h7);
        board_kind = 2'd0; board_dir = 1'b1; #1;
        check("s2 rst ready", 32'(board_ready), 0);

        // Timeout instance: 2 crew only -> abort after 8 LOADING cycles
        @(negedge clk);
        rst_t = 1'b0;
        start_t = 1'b1;
        @(negedge clk);            // after start edge: LOADING, timer 0
        start_t = 1'b0;
        valid_t = 1'b1; kind_t = 2'd0; dir_t = 1'b1;
        @(negedge clk);
        @(negedge clk);
        valid_t = 1'b0;
        check("to crew2", 32'(crew_t), 2);
        repeat (5) @(negedge clk); // last LOADING cycle
        check("to loading busy", 32'(busy_t), 1);
        check("to loading done", 32'(done_t), 0);
        @(negedge clk);            // CHECK
        check("to chk busy", 32'(busy_t), 1);
        check("to chk done", 32'(done_t), 0);
        @(negedge clk);            // DONE entry
        check("to done", 32'(done_t), 1);
        check("to ns", 32'(ns_t), 32'h7);
        check("to crew held", 32'(crew_t), 2);
        @(negedge clk);
        check("to done pulse", 32'(done_t), 0);
        check("to crew held2", 32'(crew_t), 2);
        check("to ns held", 32'(ns_t), 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
